// File: rtl/rv32_tb_pkg.sv
// Shared types and constants for the instruction stream generator.
package rv32_tb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I      = 7'b0010011;

endpackage

// File: rtl/instr_stream_gen_if.sv
// Loader/control and fetch-side signals of instr_stream_gen.
// INSTR_STREAM_PERF_EN adds the performance counter outputs.
interface instr_stream_gen_if #(
    parameter int XLEN = 32,
    parameter int AW   = 4
);
    logic            LOAD_EN;
    logic [AW-1:0]   LOAD_ADDR;
    logic [XLEN-1:0] LOAD_DATA;
    logic [AW:0]     PROG_LEN;
    logic            START;
    logic            STALL;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] INSTRUCTION;
    logic            VALID;
    logic            BUSY;
    logic            DONE;
`ifdef INSTR_STREAM_PERF_EN
    logic [31:0]     CYCLE_COUNT;
    logic [31:0]     ISSUE_COUNT;
    logic [31:0]     STALL_COUNT;

    modport master (
        output LOAD_EN, LOAD_ADDR, LOAD_DATA, PROG_LEN, START, STALL,
        input  PC, INSTRUCTION, VALID, BUSY, DONE,
        input  CYCLE_COUNT, ISSUE_COUNT, STALL_COUNT
    );
    modport slave (
        input  LOAD_EN, LOAD_ADDR, LOAD_DATA, PROG_LEN, START, STALL,
        output PC, INSTRUCTION, VALID, BUSY, DONE,
        output CYCLE_COUNT, ISSUE_COUNT, STALL_COUNT
    );
`else
    modport master (
        output LOAD_EN, LOAD_ADDR, LOAD_DATA, PROG_LEN, START, STALL,
        input  PC, INSTRUCTION, VALID, BUSY, DONE
    );
    modport slave (
        input  LOAD_EN, LOAD_ADDR, LOAD_DATA, PROG_LEN, START, STALL,
        output PC, INSTRUCTION, VALID, BUSY, DONE
    );
`endif
endinterface

// File: rtl/instr_stream_store.sv
// Program store: one synchronous write port, one asynchronous read port.
module instr_stream_store #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_stream_gen.sv
// Instruction sequencer feeding a CPU's PC/INSTRUCTION fetch ports, then draining with NOPs.
// Optional performance counters are built when INSTR_STREAM_PERF_EN is defined.
module instr_stream_gen #(
    parameter int              XLEN         = 32,
    parameter int              DEPTH        = 16,
    parameter int              AW           = $clog2(DEPTH),
    parameter logic [XLEN-1:0] BASE_PC      = '0,
    parameter logic [XLEN-1:0] NOP_INSTR    = XLEN'(rv32_tb_pkg::NOP_INSTR),
    parameter int              DRAIN_CYCLES = 5
) (
    input logic               CLK,
    input logic               RESET,
    instr_stream_gen_if.slave bus
);
    import rv32_tb_pkg::*;

    localparam int              DW         = $clog2(DRAIN_CYCLES + 1);
    localparam logic [AW:0]     DEPTH_W    = (AW + 1)'(DEPTH);
    localparam logic [AW:0]     ONE_IDX    = (AW + 1)'(1);
    localparam logic [DW-1:0]   DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [AW:0]     idx_q, idx_d;
    logic [AW:0]     len_q, len_d;
    logic [DW-1:0]   drain_q, drain_d;

    logic            idle_like;
    logic            wr_en;
    logic [AW:0]     start_len;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign wr_en     = bus.LOAD_EN && idle_like && ({1'b0, bus.LOAD_ADDR} < DEPTH_W);
    assign start_len = (bus.PROG_LEN > DEPTH_W) ? DEPTH_W : bus.PROG_LEN;
    // Word 0 on a START edge is read combinationally, so a same-edge write is not yet visible.
    assign rd_addr   = idle_like ? '0 : idx_q[AW-1:0];

    instr_stream_store #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_store (
        .clk   (CLK),
        .we    (wr_en),
        .waddr (bus.LOAD_ADDR),
        .wdata (bus.LOAD_DATA),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
        idx_d   = idx_q;
        len_d   = len_q;
        drain_d = drain_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.START) begin
                    len_d  = start_len;
                    done_d = 1'b0;
                    busy_d = 1'b1;
                    pc_d   = BASE_PC;
                    if (start_len == '0) begin
                        state_d = ST_DRAIN;
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                        idx_d   = '0;
                        drain_d = DRAIN_LOAD;
                    end else begin
                        state_d = ST_RUN;
                        instr_d = rd_data;
                        valid_d = 1'b1;
                        idx_d   = ONE_IDX;
                    end
                end
            end
            ST_RUN: begin
                if (!bus.STALL) begin
                    pc_d = pc_q + PC_STEP;
                    if (idx_q < len_q) begin
                        instr_d = rd_data;
                        valid_d = 1'b1;
                        idx_d   = idx_q + ONE_IDX;
                    end else begin
                        state_d = ST_DRAIN;
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                        drain_d = DRAIN_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                if (!bus.STALL) begin
                    if (drain_q == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end else begin
                        drain_d = drain_q - DW'(1);
                        pc_d    = pc_q + PC_STEP;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            pc_q    <= BASE_PC;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            len_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            drain_q <= drain_d;
        end
    end

    assign bus.PC          = pc_q;
    assign bus.INSTRUCTION = instr_q;
    assign bus.VALID       = valid_q;
    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;

`ifdef INSTR_STREAM_PERF_EN
    logic [31:0] cycle_cnt, issue_cnt, stall_cnt;

    always_ff @(posedge CLK) begin
        if (RESET || (idle_like && bus.START)) begin
            cycle_cnt <= '0;
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (busy_q) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (busy_q && bus.STALL) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (valid_q && !bus.STALL) begin
                issue_cnt <= issue_cnt + 32'd1;
            end
        end
    end

    assign bus.CYCLE_COUNT = cycle_cnt;
    assign bus.ISSUE_COUNT = issue_cnt;
    assign bus.STALL_COUNT = stall_cnt;
`endif

endmodule

// File: tb/tb_instr_stream_gen.sv
// Directed self-checking bench for instr_stream_gen (DEPTH=16, DRAIN_CYCLES=5, BASE_PC=0).
module tb_instr_stream_gen;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic CLK = 1'b0;
    logic RESET;

    instr_stream_gen_if #(.XLEN(32), .AW(4)) bus ();

    instr_stream_gen #(
        .XLEN         (32),
        .DEPTH        (16),
        .BASE_PC      (32'h0000_0000),
        .NOP_INSTR    (32'h0000_0013),
        .DRAIN_CYCLES (5)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] prog [4] = '{32'h002081B3, 32'h0041E2B3, 32'h0062F3B3, 32'h0083C4B3};

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_word(input logic [3:0] addr, input logic [31:0] data);
        bus.LOAD_EN   = 1'b1;
        bus.LOAD_ADDR = addr;
        bus.LOAD_DATA = data;
        step();
        bus.LOAD_EN   = 1'b0;
    endtask

    // Runs the 4-word program; optional stall at PC=4 and optional START/LOAD_EN injection during RUN.
    task automatic run_seq(input string tag, input int stall_n, input bit inject);
        int          idx;
        logic [31:0] epc, einstr;
        logic        ev;
        bus.PROG_LEN = 5'd4;
        bus.START    = 1'b1;
        step();
        bus.START    = 1'b0;
        for (int k = 0; k < 9 + stall_n; k++) begin
            if (k <= 1) idx = k;
            else if (k <= 1 + stall_n) idx = 1;
            else idx = k - stall_n;
            epc = 32'(4 * idx);
            if (idx < 4) begin
                einstr = prog[idx];
                ev     = 1'b1;
            end else begin
                einstr = NOP;
                ev     = 1'b0;
            end
            n_checks++;
            if ({bus.PC, bus.INSTRUCTION, bus.VALID, bus.BUSY, bus.DONE} !== {epc, einstr, ev, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got pc=%h instr=%h valid=%b busy=%b done=%b, want pc=%h instr=%h valid=%b busy=1 done=0",
                         tag, k, bus.PC, bus.INSTRUCTION, bus.VALID, bus.BUSY, bus.DONE, epc, einstr, ev);
            end
            bus.STALL = (k >= 1) && (k < 1 + stall_n);
            if (inject) begin
                bus.START     = (k == 1);
                bus.LOAD_EN   = (k == 1);
                bus.LOAD_ADDR = 4'd2;
                bus.LOAD_DATA = 32'hDEAD_BEEF;
            end
            step();
        end
        bus.STALL   = 1'b0;
        bus.START   = 1'b0;
        bus.LOAD_EN = 1'b0;
        n_checks++;
        if ({bus.PC, bus.INSTRUCTION, bus.VALID, bus.BUSY, bus.DONE} !== {32'd32, NOP, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL %s done: got pc=%h instr=%h valid=%b busy=%b done=%b, want pc=00000020 instr=%h valid=0 busy=0 done=1",
                     tag, bus.PC, bus.INSTRUCTION, bus.VALID, bus.BUSY, bus.DONE, NOP);
        end
`ifdef INSTR_STREAM_PERF_EN
        n_checks++;
        if ({bus.CYCLE_COUNT, bus.ISSUE_COUNT, bus.STALL_COUNT} !== {32'(9 + stall_n), 32'd4, 32'(stall_n)}) begin
            n_fail++;
            $display("FAIL %s perf: got cycle=%0d issue=%0d stall=%0d, want cycle=%0d issue=4 stall=%0d",
                     tag, bus.CYCLE_COUNT, bus.ISSUE_COUNT, bus.STALL_COUNT, 9 + stall_n, stall_n);
        end
`endif
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        step();
        step();
        n_checks++;
        if ({bus.PC, bus.INSTRUCTION, bus.VALID, bus.BUSY, bus.DONE} !== {32'd0, NOP, 3'b000}) begin
            n_fail++;
            $display("FAIL reset: got pc=%h instr=%h valid=%b busy=%b done=%b, want pc=0 instr=%h 0/0/0",
                     bus.PC, bus.INSTRUCTION, bus.VALID, bus.BUSY, bus.DONE, NOP);
        end
        RESET = 1'b0;
        step();
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) load_word(4'(i), prog[i]);
        run_seq("basic", 0, 1'b0);
    endtask

    task automatic test_stall();
        run_seq("stall", 2, 1'b0);
    endtask

    task automatic test_reset_mid();
        bus.PROG_LEN = 5'd4;
        bus.START    = 1'b1;
        step();
        bus.START    = 1'b0;
        step();
        step();
        n_checks++;
        if (bus.PC !== 32'd8) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got pc=%h, want pc=00000008", bus.PC);
        end
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        n_checks++;
        if ({bus.PC, bus.INSTRUCTION, bus.VALID, bus.BUSY, bus.DONE} !== {32'd0, NOP, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_mid: got pc=%h instr=%h valid=%b busy=%b done=%b, want pc=0 instr=%h 0/0/0",
                     bus.PC, bus.INSTRUCTION, bus.VALID, bus.BUSY, bus.DONE, NOP);
        end
        step();
        step();
        n_checks++;
        if ({bus.PC, bus.INSTRUCTION, bus.VALID, bus.BUSY} !== {32'd0, NOP, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got pc=%h instr=%h valid=%b busy=%b, want idle", bus.PC, bus.INSTRUCTION, bus.VALID, bus.BUSY);
        end
    endtask

    task automatic test_restart();
        run_seq("restart", 0, 1'b0);
    endtask

    task automatic test_ignored();
        run_seq("ignored_in_run", 0, 1'b1);
        run_seq("store_kept", 0, 1'b0);
    endtask

    task automatic test_load_start_same_edge();
        bus.PROG_LEN  = 5'd4;
        bus.LOAD_EN   = 1'b1;
        bus.LOAD_ADDR = 4'd0;
        bus.LOAD_DATA = 32'h1234_5678;
        bus.START     = 1'b1;
        step();
        bus.LOAD_EN   = 1'b0;
        bus.START     = 1'b0;
        n_checks++;
        if ({bus.INSTRUCTION, bus.VALID} !== {prog[0], 1'b1}) begin
            n_fail++;
            $display("FAIL same_edge_old: got instr=%h valid=%b, want instr=%h valid=1", bus.INSTRUCTION, bus.VALID, prog[0]);
        end
        for (int k = 0; k < 9; k++) step();
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        n_checks++;
        if ({bus.INSTRUCTION, bus.PC} !== {32'h1234_5678, 32'd0}) begin
            n_fail++;
            $display("FAIL same_edge_new: got instr=%h pc=%h, want instr=12345678 pc=0", bus.INSTRUCTION, bus.PC);
        end
        for (int k = 0; k < 9; k++) step();
        load_word(4'd0, prog[0]);
    endtask

    task automatic test_len_zero();
        bus.PROG_LEN = 5'd0;
        bus.START    = 1'b1;
        step();
        bus.START    = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({bus.PC, bus.INSTRUCTION, bus.VALID, bus.BUSY, bus.DONE} !== {32'(4 * k), NOP, 3'b010}) begin
                n_fail++;
                $display("FAIL len_zero cycle %0d: got pc=%h instr=%h valid=%b busy=%b done=%b, want pc=%h nop 0/1/0",
                         k, bus.PC, bus.INSTRUCTION, bus.VALID, bus.BUSY, bus.DONE, 32'(4 * k));
            end
            step();
        end
        n_checks++;
        if ({bus.PC, bus.VALID, bus.BUSY, bus.DONE} !== {32'd16, 3'b001}) begin
            n_fail++;
            $display("FAIL len_zero done: got pc=%h valid=%b busy=%b done=%b, want pc=00000010 0/0/1", bus.PC, bus.VALID, bus.BUSY, bus.DONE);
        end
`ifdef INSTR_STREAM_PERF_EN
        n_checks++;
        if ({bus.CYCLE_COUNT, bus.ISSUE_COUNT, bus.STALL_COUNT} !== {32'd5, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL len_zero perf: got cycle=%0d issue=%0d stall=%0d, want 5/0/0", bus.CYCLE_COUNT, bus.ISSUE_COUNT, bus.STALL_COUNT);
        end
`endif
    endtask

    task automatic test_len_over();
        int nvalid = 0;
        int budget = 0;
        for (int i = 0; i < 16; i++) load_word(4'(i), 32'hA000_0000 | 32'(i));
        bus.PROG_LEN = 5'd20;
        bus.START    = 1'b1;
        step();
        bus.START    = 1'b0;
        while (bus.DONE !== 1'b1 && budget < 40) begin
            if (bus.VALID === 1'b1) begin
                n_checks++;
                if ({bus.PC, bus.INSTRUCTION} !== {32'(4 * nvalid), 32'hA000_0000 | 32'(nvalid)}) begin
                    n_fail++;
                    $display("FAIL len_over word %0d: got pc=%h instr=%h, want pc=%h instr=%h",
                             nvalid, bus.PC, bus.INSTRUCTION, 32'(4 * nvalid), 32'hA000_0000 | 32'(nvalid));
                end
                nvalid++;
            end
            step();
            budget++;
        end
        n_checks++;
        if (nvalid != 16 || budget != 21) begin
            n_fail++;
            $display("FAIL len_over count: got valid=%0d cycles_to_done=%0d, want valid=16 cycles_to_done=21", nvalid, budget);
        end
    endtask

    initial begin
        RESET         = 1'b1;
        bus.LOAD_EN   = 1'b0;
        bus.LOAD_ADDR = '0;
        bus.LOAD_DATA = '0;
        bus.PROG_LEN  = '0;
        bus.START     = 1'b0;
        bus.STALL     = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_reset_mid();
        test_restart();
        test_ignored();
        test_load_start_same_edge();
        test_len_zero();
        test_len_over();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want test sequence complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_stream_gen.md
Name: instr_stream_gen

Overview:
- Synthesizable, parametrised instruction sequencer that drives the CPU's PC and INSTRUCTION inputs. It replaces hand-timed instruction assignment in CPU benches.
- Holds a loadable program of up to DEPTH words and issues them at BASE_PC + 4*i. Honours a stall input from the pipeline.
- After the last instruction, drains the pipeline with NOPs and then signals completion.
- Sits between the bench/host loader and the CPU fetch ports.

Parameters:
- XLEN, 32, instruction and PC width.
- DEPTH, 16, program store depth in words (≥1, need not be a power of two).
- AW, $clog2(DEPTH), program index width.
- BASE_PC, 32'h0000_0000, PC of program word 0.
- NOP_INSTR, 32'h0000_0013, filler instruction (addi x0,x0,0).
- DRAIN_CYCLES, 5, NOP cycles issued after the last program word (≥1).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- LOAD_EN  in  1  write LOAD_DATA into the program store.
- LOAD_ADDR  in  AW  program word index.
- LOAD_DATA  in  XLEN  instruction word.
- PROG_LEN  in  AW+1  number of words to run; latched on START.
- START  in  1  begin a run (single-cycle pulse or level).
- STALL  in  1  pipeline hazard stall; holds issue.
- PC  out  XLEN  PC of the instruction presented.
- INSTRUCTION  out  XLEN  instruction presented to the CPU.
- VALID  out  1  INSTRUCTION is a program word, not filler.
- BUSY  out  1  state is RUN or DRAIN.
- DONE  out  1  run complete; sticky.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RESET). All outputs are registered.
- Reset values: state IDLE, PC=BASE_PC, INSTRUCTION=NOP_INSTR, VALID=0, BUSY=0, DONE=0, index=0, drain counter=0. The program store is not reset; its contents survive RESET.
- FSM states: IDLE, RUN, DRAIN, DONE.
- Load:
  - Writes occur only in IDLE or DONE.
  - LOAD_ADDR ≥ DEPTH: write ignored.
  - LOAD_EN in RUN or DRAIN: ignored.
  - LOAD_EN together with START on the same edge: the write completes, then the run starts. Word 0 issued on that edge uses the old contents if LOAD_ADDR=0.
- START accepted in IDLE or DONE:
  - len = min(PROG_LEN, DEPTH).
  - len=0: go to DRAIN directly, with VALID=0.
  - Otherwise, on the same edge: INSTRUCTION=mem[0], PC=BASE_PC, VALID=1, index=1, DONE=0, state RUN.
- START in RUN or DRAIN: ignored.
- RUN, with STALL=1: all outputs held, index unchanged.
- RUN, with STALL=0:
  - index<len: INSTRUCTION=mem[index], PC=BASE_PC+4*index, VALID=1, index+1.
  - index=len: INSTRUCTION=NOP_INSTR, VALID=0, PC continues +4, drain counter=DRAIN_CYCLES-1, state DRAIN.
- DRAIN:
  - Issues NOP_INSTR with VALID=0. PC advances by 4 per non-stalled cycle.
  - The counter decrements only when STALL=0.
  - When counter=0 and STALL=0: state DONE, DONE=1, BUSY=0. INSTRUCTION stays NOP_INSTR and PC holds.
- DONE is sticky until the next accepted START or RESET.
- PC arithmetic is modulo 2^XLEN; it wraps silently.
- RESET mid-run: the state returns to IDLE on that edge. No further issue occurs and the store is retained.
- Latency: first program word is visible on the START edge. The last word is followed by exactly DRAIN_CYCLES non-stalled NOP cycles, and DONE rises on the edge after those.

Optional Feature:
- Macro: INSTR_STREAM_PERF_EN.
- Defined: adds outputs CYCLE_COUNT (32), ISSUE_COUNT (32) and STALL_COUNT (32).
  - All three are cleared on RESET and on accepted START.
  - CYCLE_COUNT increments every cycle while BUSY.
  - ISSUE_COUNT increments on each non-stalled cycle with VALID=1.
  - STALL_COUNT increments on each BUSY cycle with STALL=1.
  - All three hold while in DONE.
- Undefined: none of these ports or counters exist; all other behaviour is identical.

Decomposition:
- Shared package rv32_tb_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - the NOP_INSTR constant 32'h0000_0013;
  - the RV32 opcode constants (OP_R=7'b0110011, OP_I=7'b0010011).
- Natural sub-module: instr_stream_store, a DEPTH×XLEN store with one synchronous write port and one asynchronous read port indexed by AW.

Test Plan:
- Basic run: load 0x002081B3, 0x0041E2B3, 0x0062F3B3, 0x0083C4B3; set PROG_LEN=4; pulse START; no STALL.
  - PC must read 0, 4, 8, 12 with those words and VALID=1.
  - Then 5 NOP cycles at PC 16..32, VALID=0.
  - DONE=1 on the next edge.
- Stall: same program with STALL=1 for 2 cycles while PC=4.
  - PC=4 and INSTRUCTION=0x0041E2B3 held 3 cycles total.
  - DONE rises 2 cycles later than in the basic run.
- Boundaries:
  - PROG_LEN=0: no VALID cycle; DONE after 5 NOPs.
  - PROG_LEN=20 with DEPTH=16: exactly 16 VALID cycles.
  - LOAD_ADDR=16: ignored.
- Control robustness:
  - RESET asserted at PC=8: next cycle IDLE, INSTRUCTION=0x00000013, VALID=0, DONE=0.
  - Re-START without reload reproduces the basic-run sequence.
- Ignored inputs: START and LOAD_EN during RUN are ignored; the store is unchanged and the sequence is unaffected.
- With INSTR_STREAM_PERF_EN defined, the stall case must give ISSUE_COUNT=4, STALL_COUNT=2, CYCLE_COUNT=11.
